// File: rtl/mux_pkg.sv
// Shared select-code type, legal codes and legality check for the 2:1 select block.
package mux_pkg;

    typedef logic [1:0] mux_sel_t;

    localparam mux_sel_t SEL_IN0 = 2'b00;
    localparam mux_sel_t SEL_IN1 = 2'b01;

    function automatic logic sel_legal(mux_sel_t sel);
        return (sel == SEL_IN0) || (sel == SEL_IN1);
    endfunction

endpackage

// File: rtl/mux_2x1_comb.sv
// Purely combinational 2:1 selector; illegal codes yield RST_VAL and raise the illegal flag.
module mux_2x1_comb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] data,
    output logic             illegal
);

    always_comb begin
        data    = WIDTH'(RST_VAL);
        illegal = !sel_legal(sel);
        case (sel)
            SEL_IN0: data = in0;
            SEL_IN1: data = in1;
            default: data = WIDTH'(RST_VAL);
        endcase
    end

endmodule

// File: rtl/mux_2x1_core.sv
// Registered 2:1 select block: one-cycle latency, illegal selects flagged and forced to RST_VAL.
module mux_2x1_core
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             sel_err,
    output logic [1:0]       sel_q
);

    if (WIDTH < 1) begin : g_bad_width
        $error("mux_2x1_core: WIDTH must be at least 1");
    end

    // Only narrower-than-int widths can truncate RST_VAL.
    if ((WIDTH < 32) && ((RST_VAL >> WIDTH) != 0)) begin : g_bad_rst_val
        $error("mux_2x1_core: RST_VAL does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] sel_data;
    logic             sel_illegal;

    mux_2x1_comb #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_comb (
        .in0     (in0),
        .in1     (in1),
        .sel     (sel),
        .data    (sel_data),
        .illegal (sel_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= WIDTH'(RST_VAL);
            sel_err <= 1'b0;
            sel_q   <= SEL_IN0;
        end else begin
            out     <= sel_data;
            sel_err <= sel_illegal;
            sel_q   <= sel;
        end
    end

endmodule

// File: tb/tb_mux_2x1_core.sv
// Scoreboard bench for mux_2x1_core: a 1-bit default instance and an 8-bit instance share rst/sel.
module tb_mux_2x1_core;

    localparam logic [7:0] RST8 = 8'h5A;

    typedef struct packed {
        logic       o1;
        logic [7:0] o8;
        logic       err;
        logic [1:0] sq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       a0, a1;
    logic [7:0] b0, b1;
    logic       o1, err1;
    logic [1:0] sq1;
    logic [7:0] o8;
    logic       err8;
    logic [1:0] sq8;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    mux_2x1_core u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .in0     (a0),
        .in1     (a1),
        .sel     (sel),
        .out     (o1),
        .sel_err (err1),
        .sel_q   (sq1)
    );

    mux_2x1_core #(
        .WIDTH   (8),
        .RST_VAL (32'(RST8))
    ) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .in0     (b0),
        .in1     (b1),
        .sel     (sel),
        .out     (o8),
        .sel_err (err8),
        .sel_q   (sq8)
    );

    // Drive one cycle of stimulus and push what both instances must show after the next edge.
    task automatic drive(input logic r, input logic [1:0] s, input logic x0, input logic x1,
                         input logic [7:0] y0, input logic [7:0] y1);
        exp_t x;
        rst = r; sel = s; a0 = x0; a1 = x1; b0 = y0; b1 = y1;
        if (r) begin
            x = '{o1: 1'b0, o8: RST8, err: 1'b0, sq: 2'b00};
        end else if (s == 2'b00) begin
            x = '{o1: x0, o8: y0, err: 1'b0, sq: s};
        end else if (s == 2'b01) begin
            x = '{o1: x1, o8: y1, err: 1'b0, sq: s};
        end else begin
            x = '{o1: 1'b0, o8: RST8, err: 1'b1, sq: s};
        end
        sb.push_back(x);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, 8'hFF);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks += 4;
            if (o1 !== e.o1 || o8 !== e.o8) begin n_fail++;
                $display("FAIL reset_out c%0d: got %b/%h exp %b/%h", c, o1, o8, e.o1, e.o8); end
            if (err1 !== 1'b0 || err8 !== 1'b0) begin n_fail++;
                $display("FAIL reset_err c%0d: got %b/%b exp 0", c, err1, err8); end
            if (sq1 !== 2'b00) begin n_fail++;
                $display("FAIL reset_selq1 c%0d: got %b exp 00", c, sq1); end
            if (sq8 !== 2'b00) begin n_fail++;
                $display("FAIL reset_selq8 c%0d: got %b exp 00", c, sq8); end
        end
    endtask

    // Shared by the in0/in1 phases: in0 toggles every cycle, in1 every 4 cycles.
    task automatic test_select(input logic [1:0] s, input string name);
        for (int c = 0; c < 100; c++) begin
            drive(1'b0, s, c[0], c[2], 8'($urandom), 8'($urandom));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks += 3;
            if (o1 !== e.o1) begin n_fail++;
                $display("FAIL %s_out1 c%0d: got %b exp %b", name, c, o1, e.o1); end
            if (o8 !== e.o8) begin n_fail++;
                $display("FAIL %s_out8 c%0d: got %h exp %h", name, c, o8, e.o8); end
            if (err1 !== e.err || err8 !== e.err || sq1 !== e.sq || sq8 !== e.sq) begin n_fail++;
                $display("FAIL %s_flags c%0d: got %b%b/%b/%b exp %b/%b", name, c, err1, err8,
                         sq1, sq8, e.err, e.sq); end
        end
    endtask

    task automatic test_illegal();
        logic [1:0] s;
        for (int c = 0; c < 8; c++) begin
            s = (c < 3) ? 2'b10 : (c < 6) ? 2'b11 : 2'b00;
            drive(1'b0, s, c[0], ~c[0], 8'($urandom), 8'($urandom));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks += 3;
            if (o1 !== e.o1 || o8 !== e.o8) begin n_fail++;
                $display("FAIL illegal_out c%0d: got %b/%h exp %b/%h", c, o1, o8, e.o1, e.o8); end
            if (err1 !== e.err || err8 !== e.err) begin n_fail++;
                $display("FAIL illegal_err c%0d: got %b/%b exp %b", c, err1, err8, e.err); end
            if (sq1 !== e.sq || sq8 !== e.sq) begin n_fail++;
                $display("FAIL illegal_selq c%0d: got %b/%b exp %b", c, sq1, sq8, e.sq); end
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 4; c++) begin
            drive((c == 1), 2'b01, 1'b0, 1'b1, 8'h11, 8'hC3);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks += 2;
            if (o1 !== e.o1 || o8 !== e.o8) begin n_fail++;
                $display("FAIL midrst_out c%0d: got %b/%h exp %b/%h", c, o1, o8, e.o1, e.o8); end
            if (err1 !== e.err || sq1 !== e.sq || sq8 !== e.sq) begin n_fail++;
                $display("FAIL midrst_flags c%0d: got %b/%b/%b exp %b/%b", c, err1, sq1, sq8,
                         e.err, e.sq); end
        end
    endtask

    task automatic test_wide();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, {1'b0, c[0]}, 1'b1, 1'b0, 8'hA5, 8'h3C);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks += 2;
            if (o8 !== (c[0] ? 8'h3C : 8'hA5)) begin n_fail++;
                $display("FAIL wide_out8 c%0d: got %h exp %h", c, o8, c[0] ? 8'h3C : 8'hA5); end
            if (o1 !== e.o1 || sq8 !== e.sq) begin n_fail++;
                $display("FAIL wide_misc c%0d: got %b/%b exp %b/%b", c, o1, sq8, e.o1, e.sq); end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 200; c++) begin
            drive(($urandom_range(0, 19) == 0), 2'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks += 3;
            if (o1 !== e.o1 || o8 !== e.o8) begin n_fail++;
                $display("FAIL b2b_out c%0d: got %b/%h exp %b/%h", c, o1, o8, e.o1, e.o8); end
            if (err1 !== e.err || err8 !== e.err) begin n_fail++;
                $display("FAIL b2b_err c%0d: got %b/%b exp %b", c, err1, err8, e.err); end
            if (sq1 !== e.sq || sq8 !== e.sq) begin n_fail++;
                $display("FAIL b2b_selq c%0d: got %b/%b exp %b", c, sq1, sq8, e.sq); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_select(2'b00, "sel_in0");
        test_select(2'b01, "sel_in1");
        test_illegal();
        test_mid_reset();
        test_wide();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
